// File: rtl/dense_argmax.sv
// ---------------------------------------------------------------------------
// dense_argmax
//
// Fully connected classifier layer followed by an argmax. For each class c
// the block computes
//     logit[c] = bias[c] + sum_k ((feature[k] * weight[c*N_IN + k]) >>> FRAC)
// in signed fixed point. It reports the index and value of the largest
// logit. Ties resolve to the lower class index.
//
// All three memories are external and have a 1-cycle synchronous read.
// An address driven in cycle n returns its data in cycle n+1.
//
// Optional feature:
//     DENSE_SAT_EN - when defined, each accumulate saturates to the signed
//                    32-bit range. When undefined, each accumulate wraps
//                    modulo 2^32.
//
// Ports:
//     Clk         - single clock
//     Reset       - synchronous, active-high
//     start       - request a classification (ignored while busy)
//     curdata     - feature word read from data_addr
//     curweight   - weight word read from weight_addr
//     curbias     - bias word read from bias_addr
//     data_addr   - temp RAM feature address (0 outside MAC)
//     weight_addr - weight ROM address (0 outside MAC)
//     bias_addr   - bias ROM address (0 outside BIAS_ADDR)
//     digit       - predicted class, held between completions
//     score       - winning logit, held between completions
//     busy        - high whenever the FSM is not idle
//     ready       - one-cycle pulse, aligned with the update of digit/score
// ---------------------------------------------------------------------------
module dense_argmax #(
    parameter int N_IN  = 60,
    parameter int N_OUT = 10,
    parameter int FRAC  = 16
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               start,
    input  logic signed [31:0] curdata,
    input  logic signed [31:0] curweight,
    input  logic signed [31:0] curbias,
    output logic        [13:0] data_addr,
    output logic        [13:0] weight_addr,
    output logic        [9:0]  bias_addr,
    output logic        [3:0]  digit,
    output logic signed [31:0] score,
    output logic               busy,
    output logic               ready
);

    localparam int CW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int KW = $clog2(N_IN + 1);

    typedef enum logic [2:0] {
        IDLE,
        BIAS_ADDR,
        BIAS_LOAD,
        MAC,
        COMPARE,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         c_q, c_d;
    logic [KW-1:0]         k_q, k_d;
    logic signed [31:0]    acc_q, acc_d;
    logic signed [31:0]    best_q, best_d;
    logic [3:0]            best_idx_q, best_idx_d;
    logic [3:0]            digit_q, digit_d;
    logic signed [31:0]    score_q, score_d;
    logic                  ready_q, ready_d;

    logic                  k_last;
    logic                  c_last;
    logic [KW-1:0]         k_addr;
    logic signed [63:0]    prod_full;
    logic signed [31:0]    prod_trunc;
    logic signed [31:0]    acc_sum;

    assign k_last = (k_q == KW'(N_IN));
    assign c_last = (c_q == CW'(N_OUT - 1));

    // In the final MAC cycle the address is not used. Clamp it to the last
    // valid feature so that the weight address of the last class stays
    // inside the ROM.
    assign k_addr = k_last ? KW'(N_IN - 1) : k_q;

    // Sign-extend both operands explicitly. The low 64 bits of the product
    // are then the exact signed product. The arithmetic shift drops the
    // fractional bits, and the cast keeps the low 32 bits.
    assign prod_full  = {{32{curdata[31]}}, curdata} * {{32{curweight[31]}}, curweight};
    assign prod_trunc = 32'(prod_full >>> FRAC);

`ifdef DENSE_SAT_EN
    logic [32:0] sum_wide;

    // One guard bit is enough to detect overflow of a two-operand add.
    // If the top two bits disagree, the sum left the 32-bit range.
    assign sum_wide = {acc_q[31], acc_q} + {prod_trunc[31], prod_trunc};

    always_comb begin
        acc_sum = sum_wide[31:0];
        if (sum_wide[32] != sum_wide[31]) begin
            acc_sum = sum_wide[32] ? {1'b1, 31'b0} : {1'b0, {31{1'b1}}};
        end
    end
`else
    assign acc_sum = acc_q + prod_trunc;
`endif

    // State and datapath registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            c_q        <= '0;
            k_q        <= '0;
            acc_q      <= '0;
            best_q     <= '0;
            best_idx_q <= '0;
            digit_q    <= '0;
            score_q    <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            c_q        <= c_d;
            k_q        <= k_d;
            acc_q      <= acc_d;
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
            digit_q    <= digit_d;
            score_q    <= score_d;
            ready_q    <= ready_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (start) state_d = BIAS_ADDR;
            BIAS_ADDR: state_d = BIAS_LOAD;
            BIAS_LOAD: state_d = MAC;
            MAC:       if (k_last) state_d = COMPARE;
            COMPARE:   state_d = c_last ? DONE : BIAS_ADDR;
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Counter, accumulator and result updates.
    always_comb begin
        c_d        = c_q;
        k_d        = k_q;
        acc_d      = acc_q;
        best_d     = best_q;
        best_idx_d = best_idx_q;
        digit_d    = digit_q;
        score_d    = score_q;
        ready_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) c_d = '0;
            end
            BIAS_LOAD: begin
                acc_d = curbias;
                k_d   = '0;
            end
            MAC: begin
                // The data on the inputs belongs to the address from the
                // previous cycle (index k-1). At k == 0 nothing has arrived yet.
                if (k_q != '0) acc_d = acc_sum;
                if (!k_last) k_d = k_q + KW'(1);
            end
            COMPARE: begin
                // The comparison is strict, so a tie keeps the earlier
                // (lower) class.
                if ((c_q == '0) || (acc_q > best_q)) begin
                    best_d     = acc_q;
                    best_idx_d = 4'(c_q);
                end
                if (!c_last) c_d = c_q + CW'(1);
            end
            DONE: begin
                digit_d = best_idx_q;
                score_d = best_q;
                ready_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Output decode. Addresses are only non-zero in the states that use them.
    always_comb begin
        data_addr   = '0;
        weight_addr = '0;
        bias_addr   = '0;
        case (state_q)
            BIAS_ADDR: bias_addr = 10'(c_q);
            MAC: begin
                data_addr   = 14'(k_addr);
                weight_addr = 14'(int'(c_q) * N_IN + int'(k_addr));
            end
            default: ;
        endcase
    end

    assign busy  = (state_q != IDLE);
    assign ready = ready_q;
    assign digit = digit_q;
    assign score = score_q;

endmodule

// File: tb/tb_dense_argmax.sv
// ---------------------------------------------------------------------------
// tb_dense_argmax
//
// Testbench for dense_argmax. Models the feature RAM, weight ROM and bias
// ROM with 1-cycle synchronous reads. Each scenario fills the memories and
// pushes the expected {digit, score} onto a queue when it issues start. It
// pops that entry and compares when ready pulses.
//
// Directed scenarios use hand-derived constants. The random scenario uses a
// 64-bit behavioural model of the layer.
//
// Define DENSE_SAT_EN for both the bench and the RTL to test the
// saturating build.
// ---------------------------------------------------------------------------
module tb_dense_argmax;

    localparam int N_IN  = 60;
    localparam int N_OUT = 10;
    localparam int LAT   = N_OUT * (N_IN + 4) + 1;

    logic               Clk = 1'b0;
    logic               Reset;
    logic               start;
    logic signed [31:0] curdata, curweight, curbias;
    logic        [13:0] data_addr, weight_addr;
    logic        [9:0]  bias_addr;
    logic        [3:0]  digit;
    logic signed [31:0] score;
    logic               busy, ready;

    logic signed [31:0] feat_mem [N_IN];
    logic signed [31:0] w_mem    [N_IN*N_OUT];
    logic signed [31:0] b_mem    [N_OUT];

    typedef struct {
        logic [3:0]         digit;
        logic signed [31:0] score;
    } exp_t;

    exp_t exp_q[$];

    int check_count = 0;
    int pass_count  = 0;

    dense_argmax #(.N_IN(N_IN), .N_OUT(N_OUT), .FRAC(16)) dut (
        .Clk(Clk), .Reset(Reset), .start(start),
        .curdata(curdata), .curweight(curweight), .curbias(curbias),
        .data_addr(data_addr), .weight_addr(weight_addr), .bias_addr(bias_addr),
        .digit(digit), .score(score), .busy(busy), .ready(ready)
    );

    always #5 Clk = ~Clk;

    // Synchronous-read memory models.
    always @(posedge Clk) begin
        curdata   <= feat_mem[data_addr];
        curweight <= w_mem[weight_addr];
        curbias   <= b_mem[bias_addr];
    end

    // Reference model: 64-bit products and an explicit wrap or clamp on
    // each accumulate.
    function automatic exp_t model_result();
        exp_t   e;
        int     acc;
        longint p, s;
        int     best;
        best = 0;
        e.digit = '0;
        for (int c = 0; c < N_OUT; c++) begin
            acc = b_mem[c];
            for (int k = 0; k < N_IN; k++) begin
                p = (longint'(feat_mem[k]) * longint'(w_mem[c*N_IN + k])) >>> 16;
`ifdef DENSE_SAT_EN
                s = longint'(acc) + longint'(int'(p));
                if (s > 64'sd2147483647)       acc = 32'sh7FFFFFFF;
                else if (s < -64'sd2147483648) acc = 32'sh80000000;
                else                           acc = int'(s);
`else
                s = 0;
                acc = acc + int'(p);
`endif
            end
            if (c == 0 || acc > best) begin
                best    = acc;
                e.digit = 4'(c);
            end
        end
        e.score = best;
        return e;
    endfunction

    function automatic void fill(input int fval, input int wrow, input int wval,
                                 input int bmode);
        for (int k = 0; k < N_IN; k++) feat_mem[k] = fval;
        for (int i = 0; i < N_IN*N_OUT; i++)
            w_mem[i] = (wrow >= 0 && i / N_IN == wrow) ? wval : 0;
        for (int c = 0; c < N_OUT; c++)
            case (bmode)
                1:       b_mem[c] = 10 * c;
                2:       b_mem[c] = 5;
                3:       b_mem[c] = -100 - c;
                default: b_mem[c] = 0;
            endcase
    endfunction

    // Issue one start pulse and wait, with a bound, for ready. An optional
    // second start is driven mid-run; the DUT must ignore it.
    task automatic do_run(input int extra_start_at, output int lat,
                          output bit addr_ok, output logic busy0);
        addr_ok = 1'b1;
        lat     = -1;
        @(negedge Clk);
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        busy0 = busy;
        for (int i = 1; i <= 2000; i++) begin
            start = (i == extra_start_at);
            @(negedge Clk);
            if (data_addr >= 14'(N_IN) || weight_addr >= 14'(N_IN*N_OUT) ||
                bias_addr >= 10'(N_OUT)) addr_ok = 1'b0;
            if (ready) begin
                lat = i;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        check_count++;
        if (busy !== 1'b0) $display("[TB] FAIL reset_busy got %b want 0", busy);
        else pass_count++;
        check_count++;
        if (ready !== 1'b0) $display("[TB] FAIL reset_ready got %b want 0", ready);
        else pass_count++;
        check_count++;
        if (digit !== 4'd0) $display("[TB] FAIL reset_digit got %0d want 0", digit);
        else pass_count++;
        check_count++;
        if (score !== 32'sd0) $display("[TB] FAIL reset_score got %0d want 0", score);
        else pass_count++;
        check_count++;
        if ({data_addr, weight_addr, bias_addr} !== '0)
            $display("[TB] FAIL reset_addr got %0d/%0d/%0d want 0/0/0",
                     data_addr, weight_addr, bias_addr);
        else pass_count++;
    endtask

    // Weights all 0 and bias[c] = 10*c. Also checks the exact latency and the
    // idle outputs that follow.
    task automatic test_bias_ramp();
        int lat; bit aok; logic b0; exp_t e;
        fill(32'h0001_2345, -1, 0, 1);
        exp_q.push_back('{digit: 4'd9, score: 32'sd90});
        do_run(0, lat, aok, b0);
        e = exp_q.pop_front();
        check_count++;
        if (b0 !== 1'b1) $display("[TB] FAIL ramp_busy got %b want 1", b0);
        else pass_count++;
        check_count++;
        if (lat != LAT) $display("[TB] FAIL ramp_latency got %0d want %0d", lat, LAT);
        else pass_count++;
        check_count++;
        if (!aok) $display("[TB] FAIL ramp_addr_range got out-of-range want in-range");
        else pass_count++;
        check_count++;
        if (digit !== e.digit) $display("[TB] FAIL ramp_digit got %0d want %0d", digit, e.digit);
        else pass_count++;
        check_count++;
        if (score !== e.score) $display("[TB] FAIL ramp_score got %0d want %0d", score, e.score);
        else pass_count++;
        @(negedge Clk);
        check_count++;
        if (ready !== 1'b0 || busy !== 1'b0)
            $display("[TB] FAIL ramp_after got ready=%b busy=%b want 0/0", ready, busy);
        else pass_count++;
        check_count++;
        if ({data_addr, weight_addr, bias_addr} !== '0 || digit !== e.digit)
            $display("[TB] FAIL ramp_idle got addr=%0d/%0d/%0d digit=%0d want 0/0/0 %0d",
                     data_addr, weight_addr, bias_addr, digit, e.digit);
        else pass_count++;
    endtask

    // All biases equal: a tie that must keep class 0. A stray start in the
    // middle of the run must be ignored.
    task automatic test_tie_start_ignored();
        int lat; bit aok; logic b0; exp_t e;
        fill(32'h0000_1000, -1, 0, 2);
        exp_q.push_back('{digit: 4'd0, score: 32'sd5});
        do_run(50, lat, aok, b0);
        e = exp_q.pop_front();
        check_count++;
        if (lat != LAT) $display("[TB] FAIL tie_latency got %0d want %0d", lat, LAT);
        else pass_count++;
        check_count++;
        if (digit !== e.digit) $display("[TB] FAIL tie_digit got %0d want %0d", digit, e.digit);
        else pass_count++;
        check_count++;
        if (score !== e.score) $display("[TB] FAIL tie_score got %0d want %0d", score, e.score);
        else pass_count++;
        repeat (3) @(negedge Clk);
        check_count++;
        if (busy !== 1'b0) $display("[TB] FAIL tie_no_rerun got busy=%b want 0", busy);
        else pass_count++;
    endtask

    task automatic test_row3();
        int lat; bit aok; logic b0; exp_t e;
        fill(32'h0001_0000, 3, 32'h0001_0000, 0);
        exp_q.push_back('{digit: 4'd3, score: 32'sh003C_0000});
        do_run(0, lat, aok, b0);
        e = exp_q.pop_front();
        check_count++;
        if (lat != LAT) $display("[TB] FAIL row3_latency got %0d want %0d", lat, LAT);
        else pass_count++;
        check_count++;
        if (digit !== e.digit) $display("[TB] FAIL row3_digit got %0d want %0d", digit, e.digit);
        else pass_count++;
        check_count++;
        if (score !== e.score) $display("[TB] FAIL row3_score got %h want %h", score, e.score);
        else pass_count++;
    endtask

    task automatic test_signed_compare();
        int lat; bit aok; logic b0; exp_t e;
        fill(32'h0003_0000, -1, 0, 3);
        exp_q.push_back('{digit: 4'd0, score: -32'sd100});
        do_run(0, lat, aok, b0);
        e = exp_q.pop_front();
        check_count++;
        if (digit !== e.digit) $display("[TB] FAIL signed_digit got %0d want %0d", digit, e.digit);
        else pass_count++;
        check_count++;
        if (score !== e.score) $display("[TB] FAIL signed_score got %0d want %0d", score, e.score);
        else pass_count++;
    endtask

    task automatic test_overflow();
        int lat; bit aok; logic b0; exp_t e;
        fill(32'h4000_0000, 7, 32'h0001_0000, 0);
`ifdef DENSE_SAT_EN
        exp_q.push_back('{digit: 4'd7, score: 32'sh7FFF_FFFF});
`else
        exp_q.push_back('{digit: 4'd0, score: 32'sd0});
`endif
        do_run(0, lat, aok, b0);
        e = exp_q.pop_front();
        check_count++;
        if (digit !== e.digit) $display("[TB] FAIL ovf_digit got %0d want %0d", digit, e.digit);
        else pass_count++;
        check_count++;
        if (score !== e.score) $display("[TB] FAIL ovf_score got %h want %h", score, e.score);
        else pass_count++;
    endtask

    // Reset 100 cycles into a run, then restart with the row-3 data.
    task automatic test_mid_reset();
        int lat; bit aok; logic b0; exp_t e; bit saw_ready;
        fill(32'h0001_0000, 3, 32'h0001_0000, 0);
        saw_ready = 1'b0;
        @(negedge Clk);
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clk);
            if (ready) saw_ready = 1'b1;
        end
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        if (ready) saw_ready = 1'b1;
        check_count++;
        if (busy !== 1'b0) $display("[TB] FAIL midrst_busy got %b want 0", busy);
        else pass_count++;
        @(negedge Clk);
        if (ready) saw_ready = 1'b1;
        check_count++;
        if (saw_ready) $display("[TB] FAIL midrst_no_ready got pulse want none");
        else pass_count++;
        exp_q.push_back('{digit: 4'd3, score: 32'sh003C_0000});
        do_run(0, lat, aok, b0);
        e = exp_q.pop_front();
        check_count++;
        if (lat != LAT) $display("[TB] FAIL midrst_latency got %0d want %0d", lat, LAT);
        else pass_count++;
        check_count++;
        if (digit !== e.digit || score !== e.score)
            $display("[TB] FAIL midrst_result got %0d/%h want %0d/%h",
                     digit, score, e.digit, e.score);
        else pass_count++;
    endtask

    // Two consecutive runs on random memory contents, checked against the model.
    task automatic test_random();
        int lat; bit aok; logic b0; exp_t e;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < N_IN; k++) feat_mem[k] = int'($urandom);
            for (int i = 0; i < N_IN*N_OUT; i++) w_mem[i] = int'($urandom);
            for (int c = 0; c < N_OUT; c++) b_mem[c] = int'($urandom);
            exp_q.push_back(model_result());
            do_run(0, lat, aok, b0);
            e = exp_q.pop_front();
            check_count++;
            if (lat != LAT) $display("[TB] FAIL rand%0d_latency got %0d want %0d", r, lat, LAT);
            else pass_count++;
            check_count++;
            if (digit !== e.digit || score !== e.score)
                $display("[TB] FAIL rand%0d_result got %0d/%h want %0d/%h",
                         r, digit, score, e.digit, e.score);
            else pass_count++;
        end
    endtask

    initial begin
        Reset = 1'b1;
        start = 1'b0;
        fill(0, -1, 0, 0);
        test_reset();
        test_bias_ramp();
        test_tie_start_ignored();
        test_row3();
        test_signed_compare();
        test_overflow();
        test_mid_reset();
        test_random();
        test_reset();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
